// File: rtl/unfilter_top_pkg.sv
// Shared widths, filter-type codes, FSM encoding and the per-channel PNG predictor
// used by both the unfilter datapath and the matching encoder.
package unfilter_top_pkg;

    localparam int DATA_PXL_WD = 32;
    localparam int DATA_CHN_WD = 8;
    localparam int NUM_CHN     = DATA_PXL_WD / DATA_CHN_WD;
    localparam int SIZE_W_MAX  = 64;
    localparam int SIZE_W_WD   = $clog2(SIZE_W_MAX + 1);
    localparam int SIZE_H_WD   = 10;
    localparam int LB_AW       = $clog2(SIZE_W_MAX);

    typedef logic [DATA_CHN_WD-1:0] chn_t;
    typedef logic [DATA_PXL_WD-1:0] pxl_t;

    typedef enum logic [7:0] {
        FT_NONE  = 8'd0,
        FT_SUB   = 8'd1,
        FT_UP    = 8'd2,
        FT_AVG   = 8'd3,
        FT_PAETH = 8'd4
    } filter_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PXL  = 2'd2;

    function automatic logic signed [9:0] absDiff(input logic signed [9:0] d);
        return (d < 0) ? -d : d;
    endfunction

    // Undo one channel of a PNG filter; unknown types pass the byte through.
    function automatic chn_t unfilterChn(input logic [7:0] ftype, input chn_t x,
                                         input chn_t a, input chn_t b, input chn_t c);
        logic [8:0]        avgSum;
        logic signed [9:0] sa, sb, sc, pa, pb, pc;
        chn_t              pred;
        avgSum = {1'b0, a} + {1'b0, b};
        sa     = $signed({2'b00, a});
        sb     = $signed({2'b00, b});
        sc     = $signed({2'b00, c});
        pa     = absDiff(sb - sc);
        pb     = absDiff(sa - sc);
        pc     = absDiff(sa + sb - sc - sc);
        if (pa <= pb && pa <= pc) begin
            pred = a;
        end else if (pb <= pc) begin
            pred = b;
        end else begin
            pred = c;
        end
        case (ftype)
            FT_SUB:   return x + a;
            FT_UP:    return x + b;
            FT_AVG:   return x + avgSum[8:1];
            FT_PAETH: return x + pred;
            default:  return x;
        endcase
    endfunction

endpackage

// File: rtl/unfilter_top_if.sv
// Frame control plus filtered-in / reconstructed-out pixel streams of the unfilter block.
interface unfilter_top_if;
    import unfilter_top_pkg::*;

    logic                 start_i;
    logic [SIZE_W_WD-1:0] cfg_w_i;
    logic [SIZE_H_WD-1:0] cfg_h_i;
    logic                 val_i;
    logic [DATA_PXL_WD-1:0] dat_i;
    logic                 val_o;
    logic [DATA_PXL_WD-1:0] dat_o;
    logic                 done_o;
    logic                 err_o;

    modport slave (
        input  start_i, cfg_w_i, cfg_h_i, val_i, dat_i,
        output val_o, dat_o, done_o, err_o
    );

    modport master (
        output start_i, cfg_w_i, cfg_h_i, val_i, dat_i,
        input  val_o, dat_o, done_o, err_o
    );

endinterface

// File: rtl/unfilter_top_line_buf.sv
// One-row pixel store: single write port, registered read port that holds between reads.
module unfilter_line_buf #(
    parameter int DEPTH = 64,
    parameter int WD    = 32,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [WD-1:0] wr_dat_i,
    input  logic          re_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [WD-1:0] rd_dat_o
);
    logic [WD-1:0] mem [DEPTH];
    logic [WD-1:0] rdDat_q;

    // Write-first forwarding covers one-pixel rows, where the next header's
    // read of address 0 lands on the same cycle as the previous row's write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wr_addr_i] <= wr_dat_i;
        end
        if (re_i) begin
            rdDat_q <= (we_i && (wr_addr_i == rd_addr_i)) ? wr_dat_i : mem[rd_addr_i];
        end
    end

    assign rd_dat_o = rdDat_q;

endmodule

// File: rtl/unfilter_top.sv
// PNG scanline unfilter: rebuilds RGBA pixels from per-row filter headers and filtered
// beats, keeping the previous row in a line buffer for the Up/Avg/Paeth predictors.
module unfilter_top
    import unfilter_top_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    unfilter_top_if.slave bus
);
    logic [1:0]           state_q, state_d;
    logic [SIZE_W_WD-1:0] cfgW_q, cfgW_d, col_q, col_d;
    logic [SIZE_H_WD-1:0] cfgH_q, cfgH_d, row_q, row_d;
    logic [7:0]           ftype_q, ftype_d;
    logic                 err_q, err_d, val_q, val_d, done_q, done_d;
    pxl_t                 dat_q, dat_d, upLeft_q, upLeft_d;
    logic [LB_AW-1:0]     wrAddr_q, wrAddr_d, rdAddr;
    logic                 rdEn;
    pxl_t                 lbRdDat, leftPix, upPix, upLeftPix, recon;
    logic                 hdrBeat, pixBeat, lastCol, lastRow;

    assign hdrBeat = (state_q == ST_HDR) && bus.val_i && !bus.start_i;
    assign pixBeat = (state_q == ST_PXL) && bus.val_i && !bus.start_i;
    assign lastCol = (col_q == cfgW_q - SIZE_W_WD'(1));
    assign lastRow = (row_q == cfgH_q - SIZE_H_WD'(1));

    // Row 0 and column 0 see zero neighbours no matter what the buffer holds.
    assign leftPix   = (col_q == '0) ? '0 : dat_q;
    assign upPix     = (row_q == '0) ? '0 : lbRdDat;
    assign upLeftPix = ((col_q == '0) || (row_q == '0)) ? '0 : upLeft_q;

    for (genvar g = 0; g < NUM_CHN; g++) begin : gChn
        localparam int HI = DATA_PXL_WD - 1 - g * DATA_CHN_WD;
        assign recon[HI -: DATA_CHN_WD] = unfilterChn(ftype_q,
                                                      bus.dat_i[HI -: DATA_CHN_WD],
                                                      leftPix[HI -: DATA_CHN_WD],
                                                      upPix[HI -: DATA_CHN_WD],
                                                      upLeftPix[HI -: DATA_CHN_WD]);
    end

    // Prefetch the up pixel for the next beat; nothing past the row end is read.
    assign rdEn   = hdrBeat || (pixBeat && !lastCol);
    assign rdAddr = hdrBeat ? '0 : LB_AW'(col_q + SIZE_W_WD'(1));

    unfilter_line_buf #(
        .DEPTH (SIZE_W_MAX),
        .WD    (DATA_PXL_WD),
        .AW    (LB_AW)
    ) uLineBuf (
        .clk       (clk),
        .we_i      (val_q),
        .wr_addr_i (wrAddr_q),
        .wr_dat_i  (dat_q),
        .re_i      (rdEn),
        .rd_addr_i (rdAddr),
        .rd_dat_o  (lbRdDat)
    );

    always_comb begin
        state_d  = state_q;
        cfgW_d   = cfgW_q;
        cfgH_d   = cfgH_q;
        col_d    = col_q;
        row_d    = row_q;
        ftype_d  = ftype_q;
        err_d    = err_q;
        val_d    = 1'b0;
        dat_d    = dat_q;
        done_d   = 1'b0;
        upLeft_d = upLeft_q;
        wrAddr_d = wrAddr_q;
        if (bus.start_i) begin
            state_d = ST_HDR;
            cfgW_d  = bus.cfg_w_i;
            cfgH_d  = bus.cfg_h_i;
            col_d   = '0;
            row_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_HDR: begin
                    if (bus.val_i) begin
                        ftype_d  = bus.dat_i[DATA_PXL_WD-1 -: 8];
                        err_d    = err_q || (bus.dat_i[DATA_PXL_WD-1 -: 8] > FT_PAETH);
                        col_d    = '0;
                        upLeft_d = '0;
                        state_d  = ST_PXL;
                    end
                end
                ST_PXL: begin
                    if (bus.val_i) begin
                        val_d    = 1'b1;
                        dat_d    = recon;
                        wrAddr_d = LB_AW'(col_q);
                        upLeft_d = upPix;
                        if (lastCol) begin
                            col_d = '0;
                            if (lastRow) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                row_d   = row_q + SIZE_H_WD'(1);
                                state_d = ST_HDR;
                            end
                        end else begin
                            col_d = col_q + SIZE_W_WD'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cfgW_q   <= '0;
            cfgH_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            ftype_q  <= '0;
            err_q    <= 1'b0;
            val_q    <= 1'b0;
            dat_q    <= '0;
            done_q   <= 1'b0;
            upLeft_q <= '0;
            wrAddr_q <= '0;
        end else begin
            state_q  <= state_d;
            cfgW_q   <= cfgW_d;
            cfgH_q   <= cfgH_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ftype_q  <= ftype_d;
            err_q    <= err_d;
            val_q    <= val_d;
            dat_q    <= dat_d;
            done_q   <= done_d;
            upLeft_q <= upLeft_d;
            wrAddr_q <= wrAddr_d;
        end
    end

    assign bus.val_o  = val_q;
    assign bus.dat_o  = dat_q;
    assign bus.done_o = done_q;
    assign bus.err_o  = err_q;

endmodule

// File: tb/tb_unfilter_top.sv
// Bench for unfilter_top: directed frames, a PNG reference model over whole images,
// and a per-cycle compare of the output stream against that model.
module tb_unfilter_top;
    import unfilter_top_pkg::*;

    logic clk;
    logic rstn;
    unfilter_top_if bus ();

    unfilter_top dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int doneSeen    = 0;
    int expDones    = 0;
    logic checkEn   = 1'b0;

    logic        expVal  = 1'b0;
    logic [31:0] expDat  = '0;
    logic        expDone = 1'b0;
    logic        expErr  = 1'b0;

    logic [31:0] filt  [0:2][0:3];
    logic [31:0] recon [0:2][0:3];
    logic [7:0]  types [0:2];

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int chanOf(input logic [31:0] p, input int ch);
        logic [7:0] b;
        b = p[31 - 8 * ch -: 8];
        return int'(b);
    endfunction

    function automatic int absInt(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference PNG reconstruction of a whole image, using the textbook p = a + b - c Paeth form.
    task automatic modelFrame(input int w, input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                for (int ch = 0; ch < 4; ch++) begin
                    int x, a, b, cc, p, pa, pb, pc, pr, v;
                    logic [31:0] tmp;
                    x = chanOf(filt[r][c], ch);
                    a = 0;
                    b = 0;
                    cc = 0;
                    if (c > 0) a = chanOf(recon[r][c-1], ch);
                    if (r > 0) b = chanOf(recon[r-1][c], ch);
                    if (r > 0 && c > 0) cc = chanOf(recon[r-1][c-1], ch);
                    case (types[r])
                        8'd1: v = x + a;
                        8'd2: v = x + b;
                        8'd3: v = x + (a + b) / 2;
                        8'd4: begin
                            p  = a + b - cc;
                            pa = absInt(p - a);
                            pb = absInt(p - b);
                            pc = absInt(p - cc);
                            if (pa <= pb && pa <= pc) pr = a;
                            else if (pb <= pc) pr = b;
                            else pr = cc;
                            v = x + pr;
                        end
                        default: v = x;
                    endcase
                    tmp = recon[r][c];
                    tmp[31 - 8 * ch -: 8] = v[7:0];
                    recon[r][c] = tmp;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic st, input logic v, input logic [31:0] d,
                                 input logic ev, input logic [31:0] ed, input logic edn,
                                 input logic hdrErr);
        @(negedge clk);
        bus.start_i = st;
        bus.val_i   = v;
        bus.dat_i   = d;
        expVal      = ev;
        expDat      = ed;
        expDone     = edn;
        if (st) expErr = 1'b0;
        else if (hdrErr) expErr = 1'b1;
    endtask

    // Drives a frame from filt/types; stops before pixel number maxPix when maxPix >= 0.
    task automatic runFrame(input int w, input int h, input int gap, input int maxPix, input logic startVal);
        int n;
        n = 0;
        modelFrame(w, h);
        bus.cfg_w_i = SIZE_W_WD'(w);
        bus.cfg_h_i = SIZE_H_WD'(h);
        applyStimulus(1'b1, startVal, 32'hA5A5A5A5, 1'b0, '0, 1'b0, 1'b0);
        for (int r = 0; r < h; r++) begin
            applyStimulus(1'b0, 1'b1, {types[r], 24'h5A3C96}, 1'b0, '0, 1'b0, types[r] > 8'd4);
            for (int c = 0; c < w; c++) begin
                if (n == maxPix) return;
                applyStimulus(1'b0, 1'b1, filt[r][c], 1'b1, recon[r][c],
                              (r == h - 1) && (c == w - 1), 1'b0);
                n++;
                for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, '0, 1'b0, 1'b0);
            end
        end
        expDones++;
        applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput();
        compareValue("val_o", {31'b0, bus.val_o}, {31'b0, expVal});
        if (expVal) compareValue("dat_o", bus.dat_o, expDat);
        compareValue("done_o", {31'b0, bus.done_o}, {31'b0, expDone});
        compareValue("err_o", {31'b0, bus.err_o}, {31'b0, expErr});
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.done_o) doneSeen++;
        if (checkEn) checkOutput();
    end

    initial begin
        rstn        = 1'b1;
        bus.start_i = 1'b0;
        bus.val_i   = 1'b0;
        bus.dat_i   = '0;
        bus.cfg_w_i = '0;
        bus.cfg_h_i = '0;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        compareValue("reset val_o", {31'b0, bus.val_o}, 32'd0);
        compareValue("reset dat_o", bus.dat_o, 32'd0);
        compareValue("reset done_o", {31'b0, bus.done_o}, 32'd0);
        compareValue("reset err_o", {31'b0, bus.err_o}, 32'd0);
        rstn    = 1'b1;
        checkEn = 1'b1;
        $display("[TB] reset released");

        types[0] = 8'd0; filt[0][0] = 32'h01020304; filt[0][1] = 32'h05060708;
        runFrame(2, 1, 0, -1, 1'b0);
        compareValue("pin none", recon[0][1], 32'h05060708);

        types[0] = 8'd1;
        filt[0][0] = 32'h10101010; filt[0][1] = 32'h01020304; filt[0][2] = 32'hF0FFFFFF;
        runFrame(3, 1, 1, -1, 1'b0);
        compareValue("pin sub c1", recon[0][1], 32'h11121314);
        compareValue("pin sub c2", recon[0][2], 32'h01111213);

        types[0] = 8'd0; types[1] = 8'd2;
        filt[0][0] = 32'h01010101; filt[0][1] = 32'h02020202;
        filt[1][0] = 32'h01010101; filt[1][1] = 32'hFFFFFFFF;
        runFrame(2, 2, 0, -1, 1'b0);
        compareValue("pin up c0", recon[1][0], 32'h02020202);
        compareValue("pin up c1", recon[1][1], 32'h01010101);

        types[0] = 8'd0; types[1] = 8'd3;
        filt[0][0] = 32'h0A0A0A0A; filt[0][1] = 32'h14141414;
        filt[1][0] = 32'h0; filt[1][1] = 32'h0;
        runFrame(2, 2, 0, -1, 1'b0);
        compareValue("pin avg c0", recon[1][0], 32'h05050505);
        compareValue("pin avg c1", recon[1][1], 32'h0C0C0C0C);
        types[1] = 8'd4;
        runFrame(2, 2, 0, -1, 1'b0);
        compareValue("pin paeth c0", recon[1][0], 32'h0A0A0A0A);
        compareValue("pin paeth c1", recon[1][1], 32'h14141414);

        types[0] = 8'h07; filt[0][0] = 32'h12345678;
        runFrame(1, 1, 0, -1, 1'b0);

        types[0] = 8'd0; types[1] = 8'd2; types[2] = 8'd2;
        filt[0][0] = 32'h01020304; filt[1][0] = 32'h01010101; filt[2][0] = 32'h10101010;
        runFrame(1, 3, 0, -1, 1'b0);
        compareValue("pin up w1", recon[2][0], 32'h12131415);

        types[0] = 8'd1; types[1] = 8'd4;
        filt[0][0] = 32'h01020304; filt[0][1] = 32'h10203040; filt[0][2] = 32'h7F808182;
        filt[1][0] = 32'h11111111; filt[1][1] = 32'h22222222; filt[1][2] = 32'h33333333;
        runFrame(3, 2, 0, 4, 1'b0);
        types[0] = 8'd2; types[1] = 8'd4;
        filt[0][0] = 32'h0A0B0C0D; filt[0][1] = 32'h80808080; filt[0][2] = 32'hFFEEDDCC;
        filt[1][0] = 32'h01010101; filt[1][1] = 32'h02020202; filt[1][2] = 32'h03030303;
        runFrame(3, 2, 0, -1, 1'b1);
        compareValue("pin fresh row0", recon[0][2], 32'hFFEEDDCC);

        types[0] = 8'd3; types[1] = 8'd4; types[2] = 8'd1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                filt[r][c] = 32'(32'h9E3779B9 * (r * 4 + c + 1));
        runFrame(4, 3, 1, -1, 1'b0);

        repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        checkEn = 1'b0;
        compareValue("done count", doneSeen, expDones);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
